pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the RV32I core: holds the fetch PC and selects the next PC.
//  Next-PC sources: sequential (+4), execute-stage redirect, trap vector, return-address-stack (RAS) prediction.
//  Adds stall hold, misaligned-target detection with EPC capture, and a circular RAS of RAS_DEPTH entries.
//  Sits between the fetch stage (consumes pc) and execute/control (drives redirect, stall, RAS push/pop).
// PARAMETERS
//  XLEN       32       PC / address width in bits
//  RESET_VEC  32'h0    PC value loaded on reset
//  TRAP_VEC   32'h100  PC loaded on trap or misaligned redirect
//  RAS_DEPTH  4        RAS entries; power of 2, >=2
// PORTS
//  clk              in   1     rising-edge clock
//  reset_n          in   1     asynchronous, active-low reset
//  stall            in   1     hold PC and RAS this cycle (trap overrides)
//  trap             in   1     take trap: next PC = TRAP_VEC
//  redirect_valid   in   1     branch/jump resolved taken
//  redirect_target  in   XLEN  redirect destination
//  ras_push         in   1     call at current pc: push pc+4
//  ras_pop          in   1     return at current pc: predict next PC = RAS top
//  pc               out  XLEN  current fetch PC (registered)
//  pc_plus4         out  XLEN  pc + 4 (combinational, wraps modulo 2^XLEN)
//  epc              out  XLEN  PC captured at last trap/misalign (registered)
//  misalign_err     out  1     1-cycle pulse: redirect_target[1:0] != 0 was taken
//  ras_empty        out  1     RAS count == 0
//  ras_full         out  1     RAS count == RAS_DEPTH
// BEHAVIOUR
//  Reset (reset_n low, async): pc=RESET_VEC, epc=0, misalign_err=0, RAS count=0, top ptr=0, entries=0.
//  Per rising edge, priority (highest first):
//   1 trap:  pc<=TRAP_VEC, epc<=pc; RAS untouched; ignores stall/redirect/push/pop.
//   2 stall: pc, epc, RAS hold; redirect/push/pop this cycle are dropped (caller re-asserts).
//   3 redirect_valid & target[1:0]!=0: pc<=TRAP_VEC, epc<=pc, misalign_err<=1 next cycle only.
//   4 redirect_valid aligned: pc<=redirect_target.
//   5 ras_pop & !ras_empty: pc<=RAS top entry.
//   6 otherwise: pc<=pc+4 (0xFFFF_FFFC wraps to 0).
//  misalign_err is registered; deasserts the cycle after unless re-triggered.
//  RAS (updates only when !trap & !stall; independent of redirect, which only selects pc):
//   - push only: write pc+4 at top+1, top++, count=min(count+1,RAS_DEPTH); full -> overwrite oldest (ptr wraps).
//   - pop only: top--, count--; pop when empty ignored (no underflow, pc falls to rule 6).
//   - push&pop same cycle: top entry replaced by pc+4, count unchanged; if empty behaves as push.
//   - pop prediction uses the pre-update top entry.
//  Pointer arithmetic modulo RAS_DEPTH; all outputs registered except pc_plus4, ras_empty, ras_full (decode of count).
//  reset_n asserted mid-operation: all state returns to reset values immediately; first fetch after release = RESET_VEC.
// TESTING
//  T1 reset release, no inputs 4 cycles -> pc 0,4,8,C,10; ras_empty=1, misalign_err=0.
//  T2 stall high 3 cycles at pc=8 with redirect_valid=1 target 0x40 -> pc stays 8; after stall low, pc=0xC.
//  T3 redirect target 0x42 at pc=0x10 -> pc=0x100, epc=0x10, misalign_err=1 for exactly one cycle.
//  T4 trap & redirect & stall same cycle at pc=0x20 -> pc=0x100, epc=0x20, RAS unchanged.
//  T5 push at 0x0,0x4,0x8,0xC,0x10 (depth 4) then 5 pops -> predictions 0x14,0x10,0xC,0x8, 5th pop ignored (pc+4), ras_empty=1.
//  T6 push&pop same cycle at pc=0x30 with top=0x8 -> next pc=0x8, top becomes 0x34, count unchanged; reset_n pulse mid-run -> pc=0 async.

Source files
------------

// File: rtl/pc_unit_if.sv
// Handshake bundle between execute/control and the program-counter unit.
// Control drives redirect/stall/RAS requests; the PC unit returns fetch PC and status.
interface pc_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            trap;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] epc;
  logic            misalign_err;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, trap, redirect_valid, redirect_target, ras_push, ras_pop,
    input  pc, pc_plus4, epc, misalign_err, ras_empty, ras_full
  );

  modport slave (
    input  stall, trap, redirect_valid, redirect_target, ras_push, ras_pop,
    output pc, pc_plus4, epc, misalign_err, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC selection (trap, stall, redirect,
// return-address prediction, sequential) plus a circular return-address stack.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   reset_ni,
  pc_unit_if.slave bus
);

  localparam int unsigned PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNTW = PTRW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PTRW-1:0] top_q, top_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            ras_we;
  logic [PTRW-1:0] ras_widx;
  logic [XLEN-1:0] pc_plus4;
  logic            ras_empty;
  logic            ras_full;

  assign pc_plus4  = pc_q + XLEN'(4);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == CNTW'(RAS_DEPTH));

  // The top pointer always names the newest live entry; a push writes one slot
  // above it, so a full stack naturally overwrites its oldest entry on wrap.
  always_comb begin
    pc_d       = pc_q;
    epc_d      = epc_q;
    misalign_d = 1'b0;
    top_d      = top_q;
    count_d    = count_q;
    ras_we     = 1'b0;
    ras_widx   = top_q;

    if (bus.trap) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (!bus.stall) begin
      if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) begin
        pc_d       = TRAP_VEC;
        epc_d      = pc_q;
        misalign_d = 1'b1;
      end else if (bus.redirect_valid) begin
        pc_d = bus.redirect_target;
      end else if (bus.ras_pop && !ras_empty) begin
        pc_d = ras_q[top_q];
      end else begin
        pc_d = pc_plus4;
      end

      if (bus.ras_push && bus.ras_pop && !ras_empty) begin
        ras_we   = 1'b1;
        ras_widx = top_q;
      end else if (bus.ras_push) begin
        ras_we   = 1'b1;
        ras_widx = top_q + PTRW'(1);
        top_d    = top_q + PTRW'(1);
        if (!ras_full) begin
          count_d = count_q + CNTW'(1);
        end
      end else if (bus.ras_pop && !ras_empty) begin
        top_d   = top_q - PTRW'(1);
        count_d = count_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q       <= RESET_VEC;
      epc_q      <= '0;
      misalign_q <= 1'b0;
      top_q      <= '0;
      count_q    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      misalign_q <= misalign_d;
      top_q      <= top_d;
      count_q    <= count_d;
      if (ras_we) begin
        ras_q[ras_widx] <= pc_plus4;
      end
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.epc          = epc_q;
  assign bus.misalign_err = misalign_q;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus a randomized run against a queue-based
// behavioural model of the PC and return-address stack.
module tb_pc_unit;

  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] TRAP_VEC  = 32'h100;
  localparam int          RAS_DEPTH = 4;

  logic clk;
  logic reset_ni;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] mPc;
  logic [31:0] mEpc;
  logic        mMis;
  logic [31:0] mRas[$];

  pc_unit_if #(.XLEN(32)) bus ();

  pc_unit #(
    .XLEN(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    bus.stall           = 1'b0;
    bus.trap            = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.ras_push        = 1'b0;
    bus.ras_pop         = 1'b0;
  endtask

  task automatic modelReset();
    mPc  = RESET_VEC;
    mEpc = 32'h0;
    mMis = 1'b0;
    mRas.delete();
  endtask

  // Drives one cycle of requests, clocks the DUT and advances the model by the
  // architectural rules; returns 1ns after the edge so outputs can be sampled.
  task automatic applyStimulus(input logic tr, input logic st, input logic rv,
                               input logic [31:0] tg, input logic pu, input logic po);
    logic [31:0] oldPc;
    bus.trap            = tr;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tg;
    bus.ras_push        = pu;
    bus.ras_pop         = po;
    oldPc = mPc;
    mMis  = 1'b0;
    if (tr) begin
      mPc  = TRAP_VEC;
      mEpc = oldPc;
    end else if (!st) begin
      if (rv && tg[1:0] != 2'b00) begin
        mPc  = TRAP_VEC;
        mEpc = oldPc;
        mMis = 1'b1;
      end else if (rv) begin
        mPc = tg;
      end else if (po && mRas.size() > 0) begin
        mPc = mRas[$];
      end else begin
        mPc = oldPc + 32'd4;
      end
      if (pu && po && mRas.size() > 0) begin
        mRas[mRas.size()-1] = oldPc + 32'd4;
      end else if (pu) begin
        if (mRas.size() == RAS_DEPTH) void'(mRas.pop_front());
        mRas.push_back(oldPc + 32'd4);
      end else if (po && mRas.size() > 0) begin
        void'(mRas.pop_back());
      end
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic doReset();
    clearInputs();
    reset_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    doReset();
    checkCount++;
    if (bus.pc !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_pc got %h expected %h", bus.pc, 32'h0); end
    checkCount++;
    if (bus.epc !== 32'h0) begin errorCount++; $display("[TB] FAIL reset_epc got %h expected %h", bus.epc, 32'h0); end
    checkCount++;
    if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0 || bus.misalign_err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_flags got empty=%b full=%b mis=%b expected 1 0 0",
               bus.ras_empty, bus.ras_full, bus.misalign_err);
    end
    checkCount++;
    if (bus.pc_plus4 !== 32'h4) begin errorCount++; $display("[TB] FAIL reset_pc_plus4 got %h expected %h", bus.pc_plus4, 32'h4); end
  endtask

  task automatic test_sequential();
    doReset();
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 0, 0);
      checkCount++;
      if (bus.pc !== 32'(4 * i)) begin
        errorCount++;
        $display("[TB] FAIL seq_pc step %0d got %h expected %h", i, bus.pc, 32'(4 * i));
      end
    end
    checkCount++;
    if (bus.ras_empty !== 1'b1 || bus.misalign_err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL seq_flags got empty=%b mis=%b expected 1 0", bus.ras_empty, bus.misalign_err);
    end
  endtask

  task automatic test_stall();
    doReset();
    repeat (2) applyStimulus(0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 32'h40, 1, 0);
      checkCount++;
      if (bus.pc !== 32'h8) begin errorCount++; $display("[TB] FAIL stall_hold cycle %0d got %h expected %h", i, bus.pc, 32'h8); end
    end
    checkCount++;
    if (bus.ras_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL stall_ras got empty=%b expected 1", bus.ras_empty); end
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkCount++;
    if (bus.pc !== 32'hC) begin errorCount++; $display("[TB] FAIL stall_release got %h expected %h", bus.pc, 32'hC); end
  endtask

  task automatic test_misalign();
    doReset();
    repeat (4) applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 1, 32'h42, 0, 0);
    checkCount++;
    if (bus.pc !== TRAP_VEC || bus.epc !== 32'h10 || bus.misalign_err !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL misalign_take got pc=%h epc=%h mis=%b expected %h %h 1",
               bus.pc, bus.epc, bus.misalign_err, TRAP_VEC, 32'h10);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkCount++;
    if (bus.misalign_err !== 1'b0 || bus.pc !== 32'h104) begin
      errorCount++;
      $display("[TB] FAIL misalign_pulse got mis=%b pc=%h expected 0 %h", bus.misalign_err, bus.pc, 32'h104);
    end
  endtask

  task automatic test_trap();
    doReset();
    applyStimulus(0, 0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 1, 32'h20, 0, 0);
    applyStimulus(1, 1, 1, 32'h80, 1, 1);
    checkCount++;
    if (bus.pc !== TRAP_VEC || bus.epc !== 32'h20) begin
      errorCount++;
      $display("[TB] FAIL trap_take got pc=%h epc=%h expected %h %h", bus.pc, bus.epc, TRAP_VEC, 32'h20);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    checkCount++;
    if (bus.pc !== 32'h4 || bus.ras_empty !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL trap_ras got pc=%h empty=%b expected %h 1", bus.pc, bus.ras_empty, 32'h4);
    end
  endtask

  task automatic test_ras();
    logic [31:0] expPred [5];
    expPred = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};
    doReset();
    repeat (5) applyStimulus(0, 0, 0, 32'h0, 1, 0);
    checkCount++;
    if (bus.ras_full !== 1'b1 || bus.pc !== 32'h14) begin
      errorCount++;
      $display("[TB] FAIL ras_full got full=%b pc=%h expected 1 %h", bus.ras_full, bus.pc, 32'h14);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 0, 1);
      checkCount++;
      if (bus.pc !== expPred[i]) begin
        errorCount++;
        $display("[TB] FAIL ras_pop %0d got %h expected %h", i, bus.pc, expPred[i]);
      end
    end
    checkCount++;
    if (bus.ras_empty !== 1'b1) begin errorCount++; $display("[TB] FAIL ras_empty got %b expected 1", bus.ras_empty); end
  endtask

  task automatic test_push_pop();
    doReset();
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 1, 0);
    applyStimulus(0, 0, 1, 32'h30, 0, 0);
    applyStimulus(0, 0, 0, 32'h0, 1, 1);
    checkCount++;
    if (bus.pc !== 32'h8 || bus.ras_empty !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL pushpop_pred got pc=%h empty=%b expected %h 0", bus.pc, bus.ras_empty, 32'h8);
    end
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    checkCount++;
    if (bus.pc !== 32'h34 || bus.ras_empty !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL pushpop_top got pc=%h empty=%b expected %h 1", bus.pc, bus.ras_empty, 32'h34);
    end
  endtask

  task automatic test_wrap();
    doReset();
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkCount++;
    if (bus.pc_plus4 !== 32'h0) begin errorCount++; $display("[TB] FAIL wrap_plus4 got %h expected %h", bus.pc_plus4, 32'h0); end
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkCount++;
    if (bus.pc !== 32'h0) begin errorCount++; $display("[TB] FAIL wrap_pc got %h expected %h", bus.pc, 32'h0); end
  endtask

  task automatic test_async_reset();
    doReset();
    repeat (3) applyStimulus(0, 0, 0, 32'h0, 1, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    #2;
    reset_ni = 1'b0;
    #1;
    modelReset();
    checkCount++;
    if (bus.pc !== RESET_VEC || bus.epc !== 32'h0 || bus.ras_empty !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL async_reset got pc=%h epc=%h empty=%b expected %h 0 1",
               bus.pc, bus.epc, bus.ras_empty, RESET_VEC);
    end
    @(posedge clk);
    #1;
    reset_ni = 1'b1;
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkCount++;
    if (bus.pc !== 32'h4) begin errorCount++; $display("[TB] FAIL async_release got %h expected %h", bus.pc, 32'h4); end
  endtask

  task automatic test_random();
    logic        tr, st, rv, pu, po;
    logic [31:0] tg;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tr = ($urandom_range(0, 99) < 5);
      st = ($urandom_range(0, 99) < 15);
      rv = ($urandom_range(0, 99) < 20);
      pu = ($urandom_range(0, 99) < 35);
      po = ($urandom_range(0, 99) < 30);
      tg = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 9) == 0) tg = 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) tg = tg | 32'($urandom_range(1, 3));
      applyStimulus(tr, st, rv, tg, pu, po);
      checkCount++;
      if (bus.pc !== mPc || bus.epc !== mEpc || bus.misalign_err !== mMis) begin
        errorCount++;
        $display("[TB] FAIL rand_state cycle %0d got pc=%h epc=%h mis=%b expected %h %h %b",
                 cyc, bus.pc, bus.epc, bus.misalign_err, mPc, mEpc, mMis);
      end
      checkCount++;
      if (bus.ras_empty !== (mRas.size() == 0) || bus.ras_full !== (mRas.size() == RAS_DEPTH)
          || bus.pc_plus4 !== mPc + 32'd4) begin
        errorCount++;
        $display("[TB] FAIL rand_status cycle %0d got empty=%b full=%b plus4=%h expected depth %0d plus4 %h",
                 cyc, bus.ras_empty, bus.ras_full, bus.pc_plus4, mRas.size(), mPc + 32'd4);
      end
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    clearInputs();
    modelReset();
    test_reset();
    test_sequential();
    test_stall();
    test_misalign();
    test_trap();
    test_ras();
    test_push_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
